mpp_beacon_gen: RTL and testbench
=================================

# mpp_beacon_gen

Parametrised beacon frame generator, successor to the fixed 24-bit MPP20 beacon. Emits framed beacon bursts (preamble, sync, header, NUM_CH payload words, checksum) one word per clock, periodically or on demand. Payload is sampled from per-channel inputs at each frame start. Sits between the channel measurement logic and the serialiser/transmitter.

## Interface
- DATA_W, 24: word width; must be at least 16.
- NUM_CH, 4: payload channels per frame, 1..255.
- PREAMBLE_LEN, 2: preamble words, 1..15.
- PERIOD, 1280: continuous-mode frame interval in cycles; must be at least FRAME_LEN+1.
- SYNC_WORD, 24'hB5A5C3: sync word, truncated to DATA_W.

- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run enable.
- mode  in  1  0 = continuous periodic, 1 = one-shot per enable rising edge.
- ChData_in  in  NUM_CH*DATA_W  channel words; channel k at [k*DATA_W +: DATA_W].
- BeaconData_out  out  DATA_W  current frame word, 0 when not valid.
- BeaconValid_out  out  1  word valid.
- FrameStart_out  out  1  high with the first preamble word only.
- Busy_out  out  1  high from trigger cycle through last word.

## Operation
- FRAME_LEN = PREAMBLE_LEN + NUM_CH + 3 words. Sequence: preamble, sync, header, payload 0..NUM_CH-1, checksum.
- Preamble words alternate between all-ones-pattern 1010… (e.g. AAAAAA) and 0101… (555555), starting with 1010….
- Header: bits [DATA_W-1:DATA_W-8] = seq, bits [7:0] = NUM_CH, others 0.
- Checksum: sum of header and all payload words, modulo 2^DATA_W; carries discarded.
- seq: 8-bit, increments when the checksum word is output, wraps 255 to 0; reset to 0.
- States: IDLE, PREAMBLE, SYNC, HEADER, PAYLOAD, CHECK. IDLE→PREAMBLE on trigger; PREAMBLE holds PREAMBLE_LEN cycles; SYNC, HEADER 1 cycle each; PAYLOAD NUM_CH cycles; CHECK→IDLE after 1 cycle.
- Trigger, continuous mode: enable high and period counter equal to 0. Counter reloads PERIOD-1 on trigger, decrements each cycle, is held at 0 while enable low. The first trigger therefore occurs on the first cycle enable is sampled high, and later triggers occur every PERIOD cycles.
- Trigger, one-shot mode: rising edge of enable, i.e. enable high with the registered previous value low, while in IDLE.
- ChData_in is latched on the trigger cycle. Input changes during a frame do not affect it.
- Triggers arriving while not in IDLE are dropped and are not queued.
- enable deasserted mid-frame: the frame completes, then no further triggers.
- mode change is honoured only in IDLE.

## Timing
- Reset: BeaconData_out=0, BeaconValid_out=0, FrameStart_out=0, Busy_out=0, state IDLE, seq=0, period counter 0, registered enable 0. The reset is asynchronous and takes effect immediately, including mid-frame; the partial frame is abandoned.
- All outputs are registered.
- Trigger sampled at edge t: Busy_out high from t+1. First preamble word, with FrameStart_out, appears at t+1. Words occupy t+1 … t+FRAME_LEN with BeaconValid_out continuously high.
- Busy_out, BeaconValid_out and BeaconData_out return to 0 at t+FRAME_LEN+1.
- In one-shot mode, the earliest next frame is 1 cycle after Busy_out falls.

## Structure
- Package mpp_beacon_pkg holds:
  - state enum;
  - preamble pattern functions, parametrised by width;
  - SEQ_W=8 constant;
  - FRAME_LEN function of the parameters.
- Sub-module mpp_beacon_timer holds the period counter plus one-shot edge detector and outputs a single-cycle trigger pulse.
- Frame FSM, payload latch and checksum accumulator stay in mpp_beacon_gen.

## Test plan
All scenarios use DATA_W=24, NUM_CH=2, PREAMBLE_LEN=2, PERIOD=16, ChData_in = {000020, 000010}, mode=0.
- Continuous frame: enable high. Words are AAAAAA, 555555, B5A5C3, 000002, 000010, 000020, 000032 with valid high. FrameStart_out is high on AAAAAA only.
- Continuous repetition: the second frame starts 16 cycles after the first, with header 010002 and checksum 010032. seq 255 wraps so the next header is 000002.
- Enable drop: enable low during the 4th word. The frame completes through 000032 and no later frame occurs. Change ChData_in mid-frame; the payload stays 000010/000020.
- One-shot: set mode=1 and pulse enable for 1 cycle, then 5 cycles. Each pulse produces exactly one frame. An enable edge during Busy_out produces no extra frame.
- Checksum overflow: set channels to FFFFFF and 000002 with seq 0. Checksum = 000003, with header 000002 plus FFFFFF plus 000002, modulo 2^24.
- Reset mid-frame: assert Rst_n low during PAYLOAD. All outputs go to 0 without waiting for a clock edge. After release with enable high, a full frame starts with header 000002.

Source files
------------

// File: rtl/mpp_beacon_pkg.sv
// Shared types and helpers for the MPP beacon generator: frame FSM states,
// preamble bit patterns and frame-length arithmetic.
package mpp_beacon_pkg;

    localparam int SEQ_W     = 8;
    localparam int PAT_MAX_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        HEADER,
        PAYLOAD,
        CHECK
    } state_t;

    function automatic int frame_len(input int preamble_len, input int num_ch);
        return preamble_len + num_ch + 3;
    endfunction

    // 1010... counted from bit w-1 downwards; bits at and above w stay 0.
    function automatic logic [PAT_MAX_W-1:0] preamble_hi(input int w);
        logic [PAT_MAX_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            pat[i] = (i < w) && (((w - 1 - i) % 2) == 0);
        end
        return pat;
    endfunction

    function automatic logic [PAT_MAX_W-1:0] preamble_lo(input int w);
        logic [PAT_MAX_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            pat[i] = (i < w) && (((w - 1 - i) % 2) == 1);
        end
        return pat;
    endfunction

endpackage

// File: rtl/mpp_beacon_timer.sv
// Frame trigger source: period down-counter for continuous mode and an
// enable rising-edge detector for one-shot mode; trigger is a 1-cycle pulse.
module mpp_beacon_timer #(
    parameter int PERIOD = 1280
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic mode,
    input  logic idle,
    output logic trigger
);

    localparam int                CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] period_cnt_reg;
    logic             enable_prev_reg;
    logic             cont_fire;
    logic             edge_fire;

    assign cont_fire = enable && (period_cnt_reg == '0);
    assign edge_fire = enable && !enable_prev_reg;
    // Only an idle frame FSM may accept a trigger; anything else is dropped.
    assign trigger   = idle && (mode ? edge_fire : cont_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_reg  <= '0;
            enable_prev_reg <= 1'b0;
        end else begin
            enable_prev_reg <= enable;
            if (!enable) begin
                period_cnt_reg <= '0;
            end else if (trigger) begin
                period_cnt_reg <= RELOAD;
            end else if (period_cnt_reg != '0) begin
                period_cnt_reg <= period_cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpp_beacon_gen.sv
// Beacon frame generator: preamble, sync, header, NUM_CH payload words and a
// checksum, one word per clock, triggered periodically or per enable edge.
module mpp_beacon_gen
    import mpp_beacon_pkg::*;
#(
    parameter int                DATA_W       = 24,
    parameter int                NUM_CH       = 4,
    parameter int                PREAMBLE_LEN = 2,
    parameter int                PERIOD       = 1280,
    parameter logic [DATA_W-1:0] SYNC_WORD    = DATA_W'(24'hB5A5C3)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [NUM_CH*DATA_W-1:0] ChData_in,
    output logic [DATA_W-1:0]        BeaconData_out,
    output logic                     BeaconValid_out,
    output logic                     FrameStart_out,
    output logic                     Busy_out
);

    localparam logic [PAT_MAX_W-1:0] PRE_HI_FULL = preamble_hi(DATA_W);
    localparam logic [PAT_MAX_W-1:0] PRE_LO_FULL = preamble_lo(DATA_W);
    localparam logic [DATA_W-1:0]    PRE_HI      = PRE_HI_FULL[DATA_W-1:0];
    localparam logic [DATA_W-1:0]    PRE_LO      = PRE_LO_FULL[DATA_W-1:0];
    localparam logic [7:0]           PRE_LAST    = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]           CH_LAST     = 8'(NUM_CH - 1);

    state_t            state_reg;
    logic [7:0]        idx_reg;
    logic [SEQ_W-1:0]  seq_reg;
    logic [DATA_W-1:0] csum_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              fs_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] payload_reg [NUM_CH];
    logic [DATA_W-1:0] header;
    logic              trigger;
    logic              shift;

    mpp_beacon_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .enable  (enable),
        .mode    (mode),
        .idle    (state_reg == IDLE),
        .trigger (trigger)
    );

    always_comb begin
        header                      = '0;
        header[DATA_W-1 -: SEQ_W]   = seq_reg;
        header[7:0]                 = 8'(NUM_CH);
    end

    // Payload is captured on the trigger cycle and drained through entry 0,
    // one shift per payload word emitted.
    assign shift = (state_reg == HEADER) || (state_reg == PAYLOAD);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_payload
            if (gi == NUM_CH - 1) begin : g_last
                always_ff @(posedge Clk) begin
                    if (trigger) begin
                        payload_reg[gi] <= ChData_in[gi*DATA_W +: DATA_W];
                    end
                end
            end else begin : g_mid
                always_ff @(posedge Clk) begin
                    if (trigger) begin
                        payload_reg[gi] <= ChData_in[gi*DATA_W +: DATA_W];
                    end else if (shift) begin
                        payload_reg[gi] <= payload_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    // The state names the word currently on the outputs; each branch
    // registers the word that follows it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            seq_reg   <= '0;
            csum_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            fs_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            fs_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        state_reg <= PREAMBLE;
                        idx_reg   <= '0;
                        data_reg  <= PRE_HI;
                        valid_reg <= 1'b1;
                        fs_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (idx_reg == PRE_LAST) begin
                        state_reg <= SYNC;
                        data_reg  <= SYNC_WORD;
                    end else begin
                        idx_reg   <= idx_reg + 8'd1;
                        data_reg  <= idx_reg[0] ? PRE_HI : PRE_LO;
                    end
                end
                SYNC: begin
                    state_reg <= HEADER;
                    data_reg  <= header;
                    csum_reg  <= header;
                end
                HEADER: begin
                    state_reg <= PAYLOAD;
                    idx_reg   <= '0;
                    data_reg  <= payload_reg[0];
                    csum_reg  <= csum_reg + payload_reg[0];
                end
                PAYLOAD: begin
                    if (idx_reg == CH_LAST) begin
                        state_reg <= CHECK;
                        data_reg  <= csum_reg;
                        seq_reg   <= seq_reg + 1'b1;
                    end else begin
                        idx_reg   <= idx_reg + 8'd1;
                        data_reg  <= payload_reg[0];
                        csum_reg  <= csum_reg + payload_reg[0];
                    end
                end
                CHECK: begin
                    state_reg <= IDLE;
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign BeaconData_out  = data_reg;
    assign BeaconValid_out = valid_reg;
    assign FrameStart_out  = fs_reg;
    assign Busy_out        = busy_reg;

endmodule

// File: tb/tb_mpp_beacon_gen.sv
// Bench for mpp_beacon_gen: a cycle-indexed frame model fills a scoreboard
// queue, a negedge monitor pops and compares every output cycle.
module tb_mpp_beacon_gen;

    localparam int DATA_W  = 24;
    localparam int NUM_CH  = 2;
    localparam int PRE_LEN = 2;
    localparam int PERIOD  = 16;
    localparam int FL      = PRE_LEN + NUM_CH + 3;

    logic                     Clk    = 1'b0;
    logic                     Rst_n  = 1'b1;
    logic                     enable = 1'b0;
    logic                     mode   = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]        beacon_data;
    logic                     beacon_valid;
    logic                     frame_start;
    logic                     busy;

    always #5 Clk = ~Clk;

    mpp_beacon_gen #(
        .DATA_W       (DATA_W),
        .NUM_CH       (NUM_CH),
        .PREAMBLE_LEN (PRE_LEN),
        .PERIOD       (PERIOD),
        .SYNC_WORD    (24'hB5A5C3)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .enable          (enable),
        .mode            (mode),
        .ChData_in       (ch_data),
        .BeaconData_out  (beacon_data),
        .BeaconValid_out (beacon_valid),
        .FrameStart_out  (frame_start),
        .Busy_out        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        logic              fs;
    } exp_t;

    exp_t exp_q[$];

    logic m_en_prev = 1'b0;
    bit   m_low     = 1'b1;   // enable seen low since the last frame trigger
    int   m_last    = 0;
    int   m_free    = 0;      // first cycle at which a new trigger is accepted
    int   m_seq     = 0;
    bit   m_idle;
    bit   m_trig;

    task automatic push_frame(input int t, input logic [NUM_CH*DATA_W-1:0] chv);
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] hdr;
        logic [DATA_W-1:0] sum;
        exp_t              e;
        for (int j = 0; j < PRE_LEN; j++) words.push_back((j % 2 == 0) ? 24'hAAAAAA : 24'h555555);
        words.push_back(24'hB5A5C3);
        hdr        = '0;
        hdr[23:16] = 8'(m_seq);
        hdr[7:0]   = 8'(NUM_CH);
        words.push_back(hdr);
        sum = hdr;
        for (int k = 0; k < NUM_CH; k++) begin
            words.push_back(chv[k*DATA_W +: DATA_W]);
            sum = sum + chv[k*DATA_W +: DATA_W];
        end
        words.push_back(sum);
        for (int j = 0; j < FL; j++) begin
            e.cyc  = t + j;
            e.data = words[j];
            e.fs   = (j == 0);
            exp_q.push_back(e);
        end
        m_seq = (m_seq + 1) % 256;
    endtask

    initial forever begin
        @(posedge Clk);
        cyc++;
        if (!Rst_n) begin
            m_en_prev = 1'b0;
            m_low     = 1'b1;
            m_free    = 0;
            m_seq     = 0;
        end else begin
            m_idle = (cyc >= m_free);
            if (!mode) m_trig = enable && m_idle && (m_low || (cyc - m_last) >= PERIOD);
            else       m_trig = enable && !m_en_prev && m_idle;
            if (m_trig) begin
                push_frame(cyc, ch_data);
                m_last = cyc;
                m_low  = 1'b0;
                m_free = cyc + FL + 1;
            end
            if (!enable) m_low = 1'b1;
            m_en_prev = enable;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int                frames_done = 0;
    int                fidx        = 0;
    logic [DATA_W-1:0] fbuf [FL];
    bit                ev;
    exp_t              cur;

    initial forever begin
        @(negedge Clk);
        if (!Rst_n) begin
            check("reset_valid", 32'(beacon_valid), 32'd0);
            check("reset_data",  32'(beacon_data),  32'd0);
        end else begin
            ev = 1'b0;
            if (exp_q.size() > 0) begin
                if (exp_q[0].cyc == cyc) ev = 1'b1;
            end
            check("valid", 32'(beacon_valid), 32'(ev));
            check("busy",  32'(busy),         32'(ev));
            if (ev) begin
                cur = exp_q.pop_front();
                check("data",        32'(beacon_data), 32'(cur.data));
                check("frame_start", 32'(frame_start), 32'(cur.fs));
            end else begin
                check("idle_data", 32'(beacon_data), 32'd0);
                check("idle_fs",   32'(frame_start), 32'd0);
            end
            if (beacon_valid) begin
                if (frame_start) fidx = 0;
                if (fidx < FL) fbuf[fidx] = beacon_data;
                fidx++;
                if (fidx == FL) frames_done++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) @(negedge Clk);
        check("frames_reached", 32'(frames_done), 32'(target));
    endtask

    task automatic wait_fs(input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge Clk);
            if (frame_start) found = 1'b1;
        end
        check("frame_start_seen", 32'(found), 32'd1);
    endtask

    logic [DATA_W-1:0] first_frame [FL];
    int                n0;

    initial begin
        first_frame = '{24'hAAAAAA, 24'h555555, 24'hB5A5C3, 24'h000002,
                        24'h000010, 24'h000020, 24'h000032};
        ch_data = {24'h000020, 24'h000010};
        #1 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_fs",    32'(frame_start), 32'd0);
        Rst_n = 1'b1;

        // continuous frames and seq wrap
        @(negedge Clk);
        enable = 1'b1;
        wait_frames(1, 40);
        for (int i = 0; i < FL; i++) check($sformatf("frame1_w%0d", i), 32'(fbuf[i]), 32'(first_frame[i]));
        wait_frames(2, 40);
        check("frame2_header", 32'(fbuf[3]), 32'h010002);
        check("frame2_csum",   32'(fbuf[6]), 32'h010032);
        wait_frames(257, 300 * PERIOD);
        check("wrap_header", 32'(fbuf[3]), 32'h000002);
        check("wrap_csum",   32'(fbuf[6]), 32'h000032);

        // enable dropped during the 4th word, inputs changed mid-frame
        wait_fs(40);
        n0 = frames_done;
        repeat (3) @(negedge Clk);
        enable = 1'b0;
        ch_data[23:0]  = 24'($urandom);
        ch_data[47:24] = 24'($urandom);
        wait_frames(n0 + 1, 20);
        check("drop_payload0", 32'(fbuf[4]), 32'h000010);
        check("drop_payload1", 32'(fbuf[5]), 32'h000020);
        check("drop_csum",     32'(fbuf[6]), 32'(fbuf[3] + 24'h000030));
        repeat (3 * PERIOD) @(negedge Clk);
        check("no_frame_after_drop", 32'(frames_done), 32'(n0 + 1));

        // one-shot mode
        mode    = 1'b1;
        ch_data = {24'h000020, 24'h000010};
        n0      = frames_done;
        @(negedge Clk) enable = 1'b1;
        @(negedge Clk) enable = 1'b0;
        repeat (FL + 4) @(negedge Clk);
        check("oneshot_pulse1", 32'(frames_done), 32'(n0 + 1));
        enable = 1'b1;
        repeat (5) @(negedge Clk);
        enable = 1'b0;
        repeat (FL + 4) @(negedge Clk);
        check("oneshot_pulse5", 32'(frames_done), 32'(n0 + 2));
        enable = 1'b1;
        @(negedge Clk) enable = 1'b0;
        repeat (2) @(negedge Clk);
        enable = 1'b1;
        @(negedge Clk) enable = 1'b0;
        repeat (FL + 4) @(negedge Clk);
        check("oneshot_edge_in_busy", 32'(frames_done), 32'(n0 + 3));

        // reset during PAYLOAD, then checksum overflow frame
        mode    = 1'b0;
        ch_data = {24'h000002, 24'hFFFFFF};
        enable  = 1'b1;
        wait_fs(40);
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(beacon_valid), 32'd0);
        check("async_rst_data",  32'(beacon_data),  32'd0);
        check("async_rst_fs",    32'(frame_start),  32'd0);
        check("async_rst_busy",  32'(busy),         32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        n0 = frames_done;
        wait_frames(n0 + 1, 40);
        check("post_rst_header", 32'(fbuf[3]), 32'h000002);
        check("overflow_ch0",    32'(fbuf[4]), 32'hFFFFFF);
        check("overflow_csum",   32'(fbuf[6]), 32'h000003);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 3) == 0) begin
                ch_data[23:0]  = 24'($urandom);
                ch_data[47:24] = 24'($urandom);
            end
        end
        enable = 1'b0;
        repeat (2 * FL + PERIOD) @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
